// File: rtl/park_forward.sv
// park_forward: forward Park transform for the FOC current loop.
// Rotates stationary-frame currents (Ialpha, Ibeta) by -theta into rotor-frame (Id, Iq).
// The rotation is an iterative CORDIC with one micro-rotation per clock and no multipliers
// in the loop. A single gain multiply at the end removes the CORDIC gain.
// Input packing: s_axis1 = {Ibeta, Ialpha}, s_axis2[15:0] = theta (65536 = 2*pi).
// Output packing: m_axis = {sext32(Iq), sext32(Id)}.
// Optional build macro PARK_FWD_SAT_EN: when defined, Id/Iq saturate to 16 bits;
// otherwise they wrap (two's-complement truncation to [15:0]).
module park_forward #(
  parameter int ITER     = 16,
  parameter int IW       = 20,
  parameter int GAIN_Q15 = 19898
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_axis1,
  input  logic [31:0] s_axis2,
  output logic        m_valid,
  output logic [63:0] m_axis
);

  // Datapath bits beyond the 18 needed for full-scale growth are used as fractional
  // guard bits, so the truncating shifts in the loop lose less precision.
  localparam int GUARD = IW - 18;
  localparam int SH    = 15 + GUARD;
  localparam int PW    = IW + 17;

  localparam logic [4:0]             LAST_ITER = 5'(ITER - 1);
  localparam logic signed [16:0]     Z_QTR     = 17'sd16384;
  localparam logic signed [16:0]     Z_HALF    = 17'sd32768;
  localparam logic signed [PW-1:0]   C_GAIN    = PW'(GAIN_Q15);
  localparam logic signed [PW-1:0]   C_RND     = PW'(1) <<< (SH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRE,
    ST_ROT,
    ST_GAIN
  } state_t;

  state_t               r_state;
  logic                 r_ready;
  logic                 r_mValid;
  logic [63:0]          r_mAxis;
  logic signed [IW-1:0] r_x;
  logic signed [IW-1:0] r_y;
  logic signed [16:0]   r_z;
  logic [4:0]           r_iter;

  logic                 w_accept;
  logic [15:0]          w_negTheta;
  logic signed [IW-1:0] w_xLoad;
  logic signed [IW-1:0] w_yLoad;
  logic signed [IW-1:0] w_xShift;
  logic signed [IW-1:0] w_yShift;
  logic signed [IW-1:0] w_xRot;
  logic signed [IW-1:0] w_yRot;
  logic signed [16:0]   w_atan;
  logic signed [16:0]   w_zRot;
  logic                 w_dPos;
  logic signed [PW-1:0] w_prodX;
  logic signed [PW-1:0] w_prodY;
  logic signed [PW-1:0] w_sumX;
  logic signed [PW-1:0] w_sumY;
  logic [15:0]          w_id16;
  logic [15:0]          w_iq16;
  logic                 w_unusedBits;

  // atan(2^-i) in angle units where 65536 = 2*pi, rounded to nearest
  function automatic logic signed [16:0] atanLut(input logic [4:0] idx);
    case (idx)
      5'd0:    atanLut = 17'sd8192;
      5'd1:    atanLut = 17'sd4836;
      5'd2:    atanLut = 17'sd2555;
      5'd3:    atanLut = 17'sd1297;
      5'd4:    atanLut = 17'sd651;
      5'd5:    atanLut = 17'sd326;
      5'd6:    atanLut = 17'sd163;
      5'd7:    atanLut = 17'sd81;
      5'd8:    atanLut = 17'sd41;
      5'd9:    atanLut = 17'sd20;
      5'd10:   atanLut = 17'sd10;
      5'd11:   atanLut = 17'sd5;
      5'd12:   atanLut = 17'sd3;
      5'd13:   atanLut = 17'sd1;
      5'd14:   atanLut = 17'sd1;
      default: atanLut = 17'sd0;
    endcase
  endfunction

  // Handshake and input unpacking; the upper half of s_axis2 carries nothing
  assign s_ready      = r_ready && enable;
  assign w_accept     = s_valid && s_ready;
  assign w_unusedBits = ^s_axis2[31:16];
  assign w_negTheta   = 16'd0 - s_axis2[15:0];
  assign w_xLoad      = $signed({{(IW-16){s_axis1[15]}}, s_axis1[15:0]}) <<< GUARD;
  assign w_yLoad      = $signed({{(IW-16){s_axis1[31]}}, s_axis1[31:16]}) <<< GUARD;

  // One CORDIC micro-rotation, steering the residual angle z toward zero
  assign w_atan   = atanLut(r_iter);
  assign w_dPos   = ~r_z[16];
  assign w_xShift = r_x >>> r_iter;
  assign w_yShift = r_y >>> r_iter;
  assign w_xRot   = w_dPos ? (r_x - w_yShift) : (r_x + w_yShift);
  assign w_yRot   = w_dPos ? (r_y + w_xShift) : (r_y - w_xShift);
  assign w_zRot   = w_dPos ? (r_z - w_atan)   : (r_z + w_atan);

  // Gain compensation with round-half-up, then removal of the guard bits
  assign w_prodX = PW'(r_x) * C_GAIN;
  assign w_prodY = PW'(r_y) * C_GAIN;
  assign w_sumX  = w_prodX + C_RND;
  assign w_sumY  = w_prodY + C_RND;

`ifdef PARK_FWD_SAT_EN
  localparam logic signed [PW-1:0] C_MAX = PW'(32767);
  localparam logic signed [PW-1:0] C_MIN = PW'(-32768);

  // Clamp a wide result into the int16 range
  function automatic logic [15:0] sat16(input logic signed [PW-1:0] v);
    if (v > C_MAX) begin
      sat16 = 16'h7FFF;
    end else if (v < C_MIN) begin
      sat16 = 16'h8000;
    end else begin
      sat16 = v[15:0];
    end
  endfunction

  assign w_id16 = sat16(w_sumX >>> SH);
  assign w_iq16 = sat16(w_sumY >>> SH);
`else
  assign w_id16 = 16'(w_sumX >>> SH);
  assign w_iq16 = 16'(w_sumY >>> SH);
`endif

  assign m_valid = r_mValid;
  assign m_axis  = r_mAxis;

  // Control FSM and datapath registers; everything freezes while enable is low
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_ready  <= 1'b0;
      r_mValid <= 1'b0;
      r_mAxis  <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_z      <= '0;
      r_iter   <= '0;
    end else begin
      r_mValid <= 1'b0;
      if (enable) begin
        case (r_state)
          ST_IDLE: begin
            if (w_accept) begin
              r_x     <= w_xLoad;
              r_y     <= w_yLoad;
              r_z     <= {w_negTheta[15], w_negTheta};
              r_ready <= 1'b0;
              r_state <= ST_PRE;
            end else begin
              r_ready <= 1'b1;
            end
          end
          ST_PRE: begin
            r_iter <= '0;
            if (r_z > Z_QTR) begin
              r_z <= r_z - Z_HALF;
              r_x <= -r_x;
              r_y <= -r_y;
            end else if (r_z < -Z_QTR) begin
              r_z <= r_z + Z_HALF;
              r_x <= -r_x;
              r_y <= -r_y;
            end
            r_state <= ST_ROT;
          end
          ST_ROT: begin
            r_x <= w_xRot;
            r_y <= w_yRot;
            r_z <= w_zRot;
            if (r_iter == LAST_ITER) begin
              r_state <= ST_GAIN;
            end else begin
              r_iter <= r_iter + 5'd1;
            end
          end
          ST_GAIN: begin
            r_mAxis  <= {{16{w_iq16[15]}}, w_iq16, {16{w_id16[15]}}, w_id16};
            r_mValid <= 1'b1;
            r_ready  <= 1'b1;
            r_state  <= ST_IDLE;
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_park_forward.sv
// tb_park_forward: scoreboard bench for park_forward.
// Stimulus pushes the expected (Id, Iq, latency) of each accepted word into a queue;
// a monitor pops and compares whenever m_valid is seen. Expected values come from a
// floating-point Park transform, so they are independent of the CORDIC structure.
module tb_park_forward;

  localparam real PI = 3.14159265358979;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_axis1;
  logic [31:0] s_axis2;
  logic        m_valid;
  logic [63:0] m_axis;

  int total = 0;
  int bad = 0;
  int cycleCnt = 0;

  typedef struct {
    int    id;
    int    iq;
    int    tol;
    bit    chkIq;
    int    accCyc;
    int    lat;
    string name;
  } exp_t;

  exp_t expQ[$];

  park_forward dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_axis1(s_axis1),
    .s_axis2(s_axis2),
    .m_valid(m_valid),
    .m_axis (m_axis)
  );

  // Free-running clock and cycle counter used for latency measurement
  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Count one comparison; report it if outside tolerance
  function automatic void checkOutput(input string name, input int act, input int want, input int tol);
    int diff;
    diff = act - want;
    total++;
    if (diff > tol || diff < -tol) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, want %0d (tol %0d)", name, act, want, tol);
    end
  endfunction

  // Reduce an ideal result to what a 16-bit output can carry
  function automatic int fit16(input int v);
`ifdef PARK_FWD_SAT_EN
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
`else
    logic signed [15:0] t;
    t = 16'(v);
    return int'(t);
`endif
  endfunction

  // Ideal Park transform: Id = Ia cos + Ib sin, Iq = -Ia sin + Ib cos
  task automatic refPark(input int ia, input int ib, input int th, output int id, output int iq);
    real ang;
    ang = 2.0 * PI * real'(th) / 65536.0;
    id = fit16(int'(real'(ia) * $cos(ang) + real'(ib) * $sin(ang)));
    iq = fit16(int'(-real'(ia) * $sin(ang) + real'(ib) * $cos(ang)));
  endtask

  // Present one word, wait for it to be accepted, push its expected result
  task automatic applyStimulus(input int ia, input int ib, input int th, input int tol,
                               input bit chkIq, input int extra, input string name);
    exp_t e;
    int n;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] t;
    n = 0;
    @(negedge clk);
    while (!s_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      total++;
      bad++;
      $display("[TB] FAIL %s_ready: s_ready stayed 0 for %0d cycles, want 1", name, n);
      return;
    end
    a = ia;
    b = ib;
    t = th;
    s_axis1 = {b[15:0], a[15:0]};
    s_axis2 = {16'($urandom()), t[15:0]};
    s_valid = 1'b1;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    refPark(ia, ib, th, e.id, e.iq);
    e.tol    = tol;
    e.chkIq  = chkIq;
    e.accCyc = cycleCnt;
    e.lat    = 18 + extra;
    e.name   = name;
    expQ.push_back(e);
  endtask

  // Bounded wait for all outstanding results to be checked
  task automatic waitIdle(input string name);
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (expQ.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL %s_timeout: got %0d results pending, want 0", name, expQ.size());
      expQ.delete();
    end
  endtask

  // Monitor: compare every m_valid pulse against the head of the scoreboard
  initial begin
    exp_t e;
    int actId;
    int actIq;
    forever begin
      @(negedge clk);
      if (m_valid === 1'b1) begin
        if (expQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_mvalid: got m_valid=1 at cycle %0d, want 0", cycleCnt);
        end else begin
          e = expQ.pop_front();
          actId = $signed(m_axis[31:0]);
          actIq = $signed(m_axis[63:32]);
          checkOutput({e.name, "_id"}, actId, e.id, e.tol);
          if (e.chkIq) checkOutput({e.name, "_iq"}, actIq, e.iq, e.tol);
          checkOutput({e.name, "_lat"}, cycleCnt - e.accCyc, e.lat, 0);
        end
      end
    end
  end

  // Watchdog so the run can never hang
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed and random stimulus sequence
  initial begin
    rst     = 1'b1;
    enable  = 1'b0;
    s_valid = 1'b0;
    s_axis1 = '0;
    s_axis2 = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("T1_m_axis", int'(m_axis != 64'h0), 0, 0);
    checkOutput("T1_m_valid", int'(m_valid), 0, 0);
    checkOutput("T1_s_ready", int'(s_ready), 0, 0);
    rst    = 1'b0;
    enable = 1'b1;
    @(negedge clk);
    checkOutput("T1_s_ready_after", int'(s_ready), 1, 0);
    enable = 1'b0;
    #1;
    checkOutput("T1_s_ready_en_low", int'(s_ready), 0, 0);
    enable = 1'b1;

    applyStimulus(1000, 0, 0, 2, 1'b1, 0, "T2");
    waitIdle("T2");
    applyStimulus(-600, -984, 100, 3, 1'b1, 0, "T3");
    waitIdle("T3");
    applyStimulus(1000, 500, 16384, 3, 1'b1, 0, "T4a");
    waitIdle("T4a");
    applyStimulus(1000, 500, 32768, 3, 1'b1, 0, "T4b");
    waitIdle("T4b");
    applyStimulus(32767, 32767, 8192, 3, 1'b0, 0, "T5");
    waitIdle("T5");
    applyStimulus(1000, 0, 65535, 2, 1'b1, 0, "T7_wrap");
    waitIdle("T7_wrap");

    applyStimulus(1000, 0, 0, 2, 1'b1, 5, "T6a");
    repeat (4) @(posedge clk);
    #1;
    enable = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    enable = 1'b1;
    waitIdle("T6a");

    applyStimulus(1000, 0, 0, 2, 1'b1, 0, "T6b");
    repeat (3) @(negedge clk);
    s_axis1 = {16'd7000, 16'd9000};
    s_axis2 = 32'h0000_3000;
    s_valid = 1'b1;
    checkOutput("T6b_busy_ready", int'(s_ready), 0, 0);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    waitIdle("T6b");
    repeat (25) @(posedge clk);

    applyStimulus(1000, 500, 0, 3, 1'b1, 0, "T6c");
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    expQ.delete();
    @(posedge clk);
    @(negedge clk);
    checkOutput("T6c_rst_m_axis", int'(m_axis != 64'h0), 0, 0);
    checkOutput("T6c_rst_m_valid", int'(m_valid), 0, 0);
    rst = 1'b0;
    repeat (30) @(posedge clk);

    for (int k = 0; k < 12; k++) begin
      applyStimulus(int'($urandom_range(4094)) - 2047, int'($urandom_range(4094)) - 2047,
                    int'($urandom_range(65535)), 3, 1'b1, 0, $sformatf("R%0d", k));
    end
    waitIdle("random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
